// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam logic [5:0] OP_STOP = 6'd63;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_addr;
    logic             is_load;
  } stage_rec_t;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rs;
    logic             uses_rt;
  } src_rec_t;

  // True when a stage record writes register a; $0 never matches.
  function automatic logic writes(input stage_rec_t r, input logic [REG_W-1:0] a);
    return r.valid && r.wr_en && (a != '0) && (r.wr_addr == a);
  endfunction

  // EX operand source: non-load MEM writer first, then WB writer, else register file.
  function automatic logic [1:0] fwd_sel(input stage_rec_t ex, input stage_rec_t mem,
                                         input stage_rec_t wb, input logic uses,
                                         input logic [REG_W-1:0] src);
    if (!ex.valid || !uses) return FWD_RF;
    if (writes(mem, src) && !mem.is_load) return FWD_EXMEM;
    if (writes(wb, src)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow EX/MEM/WB write-back records plus the ID-hazard and EX-forward comparators.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              bubble,
  output logic              lu_hit_c,
  output logic              ex_hit_c,
  output logic              mem_hit_c,
  output logic [1:0]        fwd_a_c,
  output logic [1:0]        fwd_b_c
);

  stage_rec_t       ex_q, mem_q, wb_q, id_rec;
  src_rec_t         ex_src_q, id_src;
  logic [REG_W-1:0] rs_w, rt_w;
  logic             rd_rs, rd_rt;
  logic             unused_wb;

  assign rs_w  = REG_W'(id_rs);
  assign rt_w  = REG_W'(id_rt);
  assign rd_rs = id_valid && id_uses_rs;
  assign rd_rt = id_valid && id_uses_rt;

  // Record entering EX: a bubble whenever ID is empty or being flushed.
  always_comb begin
    id_rec = '0;
    id_src = '0;
    if (id_valid && !bubble) begin
      id_rec.valid   = 1'b1;
      id_rec.wr_en   = id_wr_en;
      id_rec.wr_addr = REG_W'(id_wr_addr);
      id_rec.is_load = id_is_load;
      id_src.rs      = rs_w;
      id_src.rt      = rt_w;
      id_src.uses_rs = id_uses_rs;
      id_src.uses_rt = id_uses_rt;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      ex_q     <= '0;
      ex_src_q <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else begin
      ex_q     <= id_rec;
      ex_src_q <= id_src;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
    end
  end

  // WB is never a hazard source because the register file writes through.
  assign ex_hit_c  = (rd_rs && writes(ex_q, rs_w))  || (rd_rt && writes(ex_q, rt_w));
  assign mem_hit_c = (rd_rs && writes(mem_q, rs_w)) || (rd_rt && writes(mem_q, rt_w));
  assign lu_hit_c  = ex_hit_c && ex_q.is_load;

  assign fwd_a_c = fwd_sel(ex_q, mem_q, wb_q, ex_src_q.uses_rs, ex_src_q.rs);
  assign fwd_b_c = fwd_sel(ex_q, mem_q, wb_q, ex_src_q.uses_rt, ex_src_q.rt);

  assign unused_wb = wb_q.is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward control and STOP drain-and-halt sequencer for the 5-stage core.
// HAZARD_FORWARDING_EN enables EX forwarding (load-use stalls only); otherwise stall on EX/MEM writers.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              id_is_stop,
  input  logic              id_jump,
  input  logic              ex_branch_taken,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              busy,
  output logic              halt_done
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYC + 1);

  halt_state_e      state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             busy_q, halt_q;
  logic             lu_hit, ex_hit, mem_hit, hazard;
  logic [1:0]       fa, fb;
  logic             unused_sb;

  hazard_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .CLK        (CLK),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_is_load (id_is_load),
    .bubble     (idex_flush),
    .lu_hit_c   (lu_hit),
    .ex_hit_c   (ex_hit),
    .mem_hit_c  (mem_hit),
    .fwd_a_c    (fa),
    .fwd_b_c    (fb)
  );

`ifdef HAZARD_FORWARDING_EN
  assign hazard    = lu_hit;
  assign fwd_a_sel = fa;
  assign fwd_b_sel = fb;
  assign unused_sb = ^{ex_hit, mem_hit};
`else
  assign hazard    = ex_hit | mem_hit;
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
  assign unused_sb = ^{lu_hit, fa, fb};
`endif

  // Priority in RUN: taken branch > hazard stall > STOP entry > jump flush.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (hazard) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end else if (id_valid && id_is_stop) begin
          idex_flush = 1'b1;
          state_n    = ST_DRAIN;
          cnt_n      = '0;
        end else if (id_valid && id_jump) begin
          ifid_flush = 1'b1;
        end
      end
      ST_DRAIN: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        if (cnt_q == CNT_W'(DRAIN_CYC - 1)) state_n = ST_HALTED;
        else cnt_n = cnt_q + CNT_W'(1);
      end
      ST_HALTED: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      busy_q  <= (state_n == ST_DRAIN);
      halt_q  <= (state_n == ST_HALTED);
    end
  end

  assign busy      = busy_q;
  assign halt_done = halt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl; expectations follow HAZARD_FORWARDING_EN.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       we;
    logic [4:0] wa;
    logic       ld;
    logic [5:0] op;
    logic       jmp;
    logic       br;
  } ins_t;

  // Output vector: {pc_stall, ifid_stall, ifid_flush, idex_flush, fwd_a, fwd_b, busy, halt_done}
  localparam logic [9:0] Z     = 10'b0000000000;
  localparam logic [9:0] STALL = 10'b1101000000;
  localparam logic [9:0] DRN   = 10'b1101000010;
  localparam logic [9:0] HLT   = 10'b1101000001;
  localparam logic [9:0] BRF   = 10'b0011000000;
  localparam logic [9:0] JF    = 10'b0010000000;
  localparam logic [9:0] SB    = 10'b0001000000;

  logic       CLK, reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_is_stop, id_jump;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic       ex_branch_taken;
  logic       pc_stall, ifid_stall, ifid_flush, idex_flush, busy, halt_done;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [9:0] obs;
  logic [9:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .DRAIN_CYC(3)) dut (
    .CLK(CLK), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .id_is_stop(id_is_stop),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .busy(busy), .halt_done(halt_done)
  );

  assign obs = {pc_stall, ifid_stall, ifid_flush, idex_flush, fwd_a_sel, fwd_b_sel, busy, halt_done};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [9:0] fw(input logic [1:0] a, input logic [1:0] b);
    return {4'b0000, a, b, 2'b00};
  endfunction

  function automatic ins_t nop();
    ins_t x = '0;
    return x;
  endfunction

  function automatic ins_t alu(input int rd, input int rs, input int rt);
    ins_t x = '0;
    x.v = 1'b1; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = 1'b1; x.urt = 1'b1;
    x.we = 1'b1; x.wa = 5'(rd);
    return x;
  endfunction

  function automatic ins_t lw(input int rt, input int base);
    ins_t x = '0;
    x.v = 1'b1; x.rs = 5'(base); x.urs = 1'b1; x.we = 1'b1; x.wa = 5'(rt);
    x.ld = 1'b1; x.op = 6'd35;
    return x;
  endfunction

  function automatic ins_t jmp(input int rs, input logic urs);
    ins_t x = '0;
    x.v = 1'b1; x.jmp = 1'b1; x.op = 6'd2; x.rs = 5'(rs); x.urs = urs;
    return x;
  endfunction

  function automatic ins_t stop(input logic br);
    ins_t x = '0;
    x.v = 1'b1; x.op = OP_STOP; x.br = br;
    return x;
  endfunction

  task automatic drive(input ins_t x);
    reset           = x.rst;
    id_valid        = x.v;
    id_rs           = x.rs;
    id_rt           = x.rt;
    id_uses_rs      = x.urs;
    id_uses_rt      = x.urt;
    id_wr_en        = x.we;
    id_wr_addr      = x.wa;
    id_is_load      = x.ld;
    id_is_stop      = (x.op == OP_STOP);
    id_jump         = x.jmp;
    ex_branch_taken = x.br;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(nop());
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    ins_t ins[$]; logic [9:0] exs[$]; logic [9:0] want; ins_t r;
    r = nop(); r.rst = 1'b1;
    ins.push_back(r);     exs.push_back(Z);
    ins.push_back(nop()); exs.push_back(Z);
    foreach (ins[i]) begin
      drive(ins[i]); exp_q.push_back(exs[i]);
      @(negedge CLK);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL reset step %0d got %b want %b", i, obs, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_use();
    ins_t ins[$]; logic [9:0] exs[$]; logic [9:0] want;
    idle(3);
    ins.push_back(lw(1, 2));     exs.push_back(Z);
    ins.push_back(alu(2, 1, 3)); exs.push_back(STALL);
`ifdef HAZARD_FORWARDING_EN
    ins.push_back(alu(2, 1, 3)); exs.push_back(Z);
    ins.push_back(nop());        exs.push_back(fw(2'd2, 2'd0));
`else
    ins.push_back(alu(2, 1, 3)); exs.push_back(STALL);
    ins.push_back(alu(2, 1, 3)); exs.push_back(Z);
    ins.push_back(nop());        exs.push_back(Z);
`endif
    foreach (ins[i]) begin
      drive(ins[i]); exp_q.push_back(exs[i]);
      @(negedge CLK);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL load_use step %0d got %b want %b", i, obs, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_forward();
    ins_t ins[$]; logic [9:0] exs[$]; logic [9:0] want;
    idle(3);
    ins.push_back(alu(1, 2, 3)); exs.push_back(Z);
    ins.push_back(alu(1, 2, 3)); exs.push_back(Z);
`ifdef HAZARD_FORWARDING_EN
    ins.push_back(alu(4, 1, 1)); exs.push_back(Z);
    ins.push_back(alu(5, 0, 1)); exs.push_back(fw(2'd1, 2'd1));
    ins.push_back(nop());        exs.push_back(fw(2'd0, 2'd2));
    ins.push_back(nop());        exs.push_back(Z);
`else
    ins.push_back(alu(4, 1, 1)); exs.push_back(STALL);
    ins.push_back(alu(4, 1, 1)); exs.push_back(STALL);
    ins.push_back(alu(4, 1, 1)); exs.push_back(Z);
    ins.push_back(alu(5, 0, 1)); exs.push_back(Z);
    ins.push_back(nop());        exs.push_back(Z);
`endif
    foreach (ins[i]) begin
      drive(ins[i]); exp_q.push_back(exs[i]);
      @(negedge CLK);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL forward step %0d got %b want %b", i, obs, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reg_zero();
    ins_t ins[$]; logic [9:0] exs[$]; logic [9:0] want;
    idle(3);
    ins.push_back(lw(0, 2));     exs.push_back(Z);
    ins.push_back(alu(0, 0, 0)); exs.push_back(Z);
    ins.push_back(alu(5, 0, 0)); exs.push_back(Z);
    ins.push_back(nop());        exs.push_back(Z);
    ins.push_back(nop());        exs.push_back(Z);
    foreach (ins[i]) begin
      drive(ins[i]); exp_q.push_back(exs[i]);
      @(negedge CLK);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL reg_zero step %0d got %b want %b", i, obs, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_branch_over_stall();
    ins_t ins[$]; logic [9:0] exs[$]; logic [9:0] want; ins_t b;
    idle(3);
    b = alu(2, 1, 3); b.br = 1'b1;
    ins.push_back(lw(1, 2)); exs.push_back(Z);
    ins.push_back(b);        exs.push_back(BRF);
    ins.push_back(nop());    exs.push_back(Z);
    foreach (ins[i]) begin
      drive(ins[i]); exp_q.push_back(exs[i]);
      @(negedge CLK);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL branch step %0d got %b want %b", i, obs, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_jump();
    ins_t ins[$]; logic [9:0] exs[$]; logic [9:0] want;
    idle(3);
    ins.push_back(jmp(0, 1'b0)); exs.push_back(JF);
    ins.push_back(nop());        exs.push_back(Z);
    ins.push_back(lw(1, 2));     exs.push_back(Z);
    ins.push_back(jmp(1, 1'b1)); exs.push_back(STALL);
`ifdef HAZARD_FORWARDING_EN
    ins.push_back(jmp(1, 1'b1)); exs.push_back(JF);
    ins.push_back(nop());        exs.push_back(fw(2'd2, 2'd0));
`else
    ins.push_back(jmp(1, 1'b1)); exs.push_back(STALL);
    ins.push_back(jmp(1, 1'b1)); exs.push_back(JF);
    ins.push_back(nop());        exs.push_back(Z);
`endif
    foreach (ins[i]) begin
      drive(ins[i]); exp_q.push_back(exs[i]);
      @(negedge CLK);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL jump step %0d got %b want %b", i, obs, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_stop_halt();
    ins_t ins[$]; logic [9:0] exs[$]; logic [9:0] want; ins_t r;
    idle(3);
    r = nop(); r.rst = 1'b1;
    ins.push_back(stop(1'b0)); exs.push_back(SB);
    ins.push_back(nop());      exs.push_back(DRN);
    ins.push_back(alu(3, 1, 2)); exs.push_back(DRN);
    ins.push_back(nop());      exs.push_back(DRN);
    ins.push_back(nop());      exs.push_back(HLT);
    ins.push_back(jmp(0, 1'b0)); exs.push_back(HLT);
    ins.push_back(r);          exs.push_back(HLT);
    ins.push_back(nop());      exs.push_back(Z);
    foreach (ins[i]) begin
      drive(ins[i]); exp_q.push_back(exs[i]);
      @(negedge CLK);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL stop_halt step %0d got %b want %b", i, obs, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid_drain();
    ins_t ins[$]; logic [9:0] exs[$]; logic [9:0] want; ins_t r;
    r = nop(); r.rst = 1'b1;
    ins.push_back(stop(1'b0)); exs.push_back(SB);
    ins.push_back(nop());      exs.push_back(DRN);
    ins.push_back(r);          exs.push_back(DRN);
    ins.push_back(nop());      exs.push_back(Z);
    ins.push_back(nop());      exs.push_back(Z);
    foreach (ins[i]) begin
      drive(ins[i]); exp_q.push_back(exs[i]);
      @(negedge CLK);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL reset_drain step %0d got %b want %b", i, obs, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_stop_branch();
    ins_t ins[$]; logic [9:0] exs[$]; logic [9:0] want;
    ins.push_back(stop(1'b1)); exs.push_back(BRF);
    for (int k = 0; k < 5; k++) begin
      ins.push_back(nop()); exs.push_back(Z);
    end
    foreach (ins[i]) begin
      drive(ins[i]); exp_q.push_back(exs[i]);
      @(negedge CLK);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL stop_branch step %0d got %b want %b", i, obs, want); end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    ins_t r;
    r = nop(); r.rst = 1'b1;
    drive(r);
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_load_use();
    test_forward();
    test_reg_zero();
    test_branch_over_stall();
    test_jump();
    test_stop_halt();
    test_reset_mid_drain();
    test_stop_branch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB). It shadows the main control decoder's per-instruction write-back information as the instruction moves down the pipe. From that shadow state it generates PC/IF-ID stalls, bubble/flush controls and EX-stage operand forward selects. It also runs the STOP (opcode 63) drain-and-halt sequence.

## Interface
Parameters:
- REG_AW, 5, register address width
- DRAIN_CYC, 3, cycles from STOP leaving ID until the last older instruction retires from WB

Ports:
- CLK  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real (non-bubble) instruction
- id_rs, id_rt  in  REG_AW  source registers of the ID instruction
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- id_wr_en  in  1  RegWriteEN from the main decoder
- id_wr_addr  in  REG_AW  destination after the RegDst mux
- id_is_load  in  1  Mem2RegSEL from the main decoder
- id_is_stop  in  1  ID opcode == 63
- id_jump  in  1  J/JAL/JR resolved in ID
- ex_branch_taken  in  1  Beq/Bne resolved true in EX
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold the IF/ID register
- ifid_flush  out  1  clear IF/ID to a bubble
- idex_flush  out  1  load a bubble into ID/EX
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB write-back value
- busy  out  1  FSM is in DRAIN
- halt_done  out  1  core halted; sticky until reset

## Operation
- Shadow state: three stage records (EX, MEM, WB), each holding valid, wr_en, wr_addr, is_load. The EX record also holds rs, rt, uses_rs and uses_rt.
- Shadow advance: on each cycle, ID info enters EX unless idex_flush is set, in which case a bubble (valid=0) enters EX. EX→MEM→WB always advances.
- Register $0 never causes a hazard or a forward.
- The register file is write-through, so a WB-stage writer never causes a hazard for ID.
- Load-use hazard: ID reads a register that the EX record writes and EX.is_load=1. Response: pc_stall, ifid_stall and idex_flush for 1 cycle.
- Forwarding selects are computed for the EX record. The MEM match (wr_en, not is_load) has priority and gives 1. A WB match gives 2. Otherwise 0.
- Jump: id_jump sets ifid_flush, giving a 1-cycle penalty.
- Taken branch: ex_branch_taken sets ifid_flush and idex_flush, giving a 2-cycle penalty. It overrides any stall in the same cycle.
- FSM states: RUN, DRAIN, HALTED.
  - RUN → DRAIN when id_valid and id_is_stop, with no taken branch and no stall that cycle. The STOP itself enters EX as a bubble.
  - In DRAIN, pc_stall, ifid_stall and idex_flush are held at 1 and the counter counts up to DRAIN_CYC. It then goes to HALTED.
  - HALTED: halt_done=1, and all stall and flush outputs stay at 1.
- A STOP arriving in the same cycle as ex_branch_taken is flushed and the FSM stays in RUN.

## Timing
- Stall, flush and fwd outputs are combinational from the registered shadow state and the ID inputs. They are valid in the same cycle, with no extra latency.
- busy and halt_done are registered from the FSM state. halt_done rises DRAIN_CYC+1 cycles after STOP is in ID.
- Reset values: all outputs 0, all shadow records have valid=0, FSM is in RUN, counter is 0.
- Reset asserted mid-DRAIN or in HALTED returns to RUN on the next edge.
- Simultaneous load-use and jump in ID: the stall wins and the jump is re-evaluated next cycle. ifid_flush is suppressed while ifid_stall is active.

## Configuration
- HAZARD_FORWARDING_EN defined: forwarding as above, and only load-use stalls.
- HAZARD_FORWARDING_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 0.
  - The block stalls (pc_stall, ifid_stall, idex_flush) while ID reads any register written by the EX or MEM records.

## Structure
- Shared package pipe_ctrl_pkg holds the FWD_RF/FWD_EXMEM/FWD_MEMWB encodings, the halt FSM state enum, the OP_STOP=6'd63 constant, and the stage-record struct.
- One sub-module, hazard_scoreboard, holds the three stage records and the match comparators. pipe_hazard_ctrl contains the FSM, the drain counter and the output priority logic.

## Test plan
- LW $1 then ADD $2,$1,$3 → one stall cycle (pc_stall=1, idex_flush=1). Next cycle fwd_a_sel=2.
- ADD $1,… then SUB $4,$1,$1 → no stall, fwd_a_sel=fwd_b_sel=1. Without HAZARD_FORWARDING_EN: 2 stall cycles and sel=0.
- ADD $0,… then consumer of $0 → no stall, sel=0.
- BEQ taken in EX while a load-use hazard is present in ID → ifid_flush=1 and idex_flush=1, pc_stall=0.
- STOP in ID → busy next cycle, halt_done=1 after 4 cycles, stall outputs stay 1. Reset → all outputs 0.
- STOP in ID together with ex_branch_taken → stays in RUN, halt_done remains 0.
